// File: rtl/pwm_halfbridge_gen.sv
// +--------------------------------------------------------------------------+
// | pwm_halfbridge_gen                                                       |
// | Complementary half-bridge PWM with leading-edge dead times and shadowed  |
// | duty/dead-time settings. Optional soft-start: define SOFT_START_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pwm_halfbridge_gen #(
    parameter int CNT_W = 8,
    parameter int DT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] i_duty,
    input  logic [DT_W-1:0]  i_dt1,
    input  logic [DT_W-1:0]  i_dt2,
    output logic             o_c1,
    output logic             o_c2,
    output logic             o_period,
    output logic             o_ss_done
);

    localparam int              c_ext_w   = CNT_W + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_d_eff;
    logic [DT_W-1:0]  r_dt1_s;
    logic [DT_W-1:0]  r_dt2_s;

    logic               w_at_max;
    logic               w_load;
    logic [c_ext_w-1:0] w_cnt_x;
    logic [c_ext_w-1:0] w_deff_x;
    logic [c_ext_w-1:0] w_dt1_x;
    logic [c_ext_w-1:0] w_c2_start;
    logic               w_c1_on;
    logic               w_c2_on;

    assign w_at_max = (r_cnt == c_cnt_max);
    assign w_load   = !enable || w_at_max;

    // Everything compared in CNT_W+1 bits so d_eff + dt2 can exceed MAX without wrapping.
    assign w_cnt_x    = {1'b0, r_cnt};
    assign w_deff_x   = {1'b0, r_d_eff};
    assign w_dt1_x    = c_ext_w'(r_dt1_s);
    assign w_c2_start = w_deff_x + c_ext_w'(r_dt2_s);

    // c1 ends strictly before d_eff and c2 starts at or after it, so they never overlap.
    assign w_c1_on = (w_cnt_x >= w_dt1_x) && (w_cnt_x < w_deff_x);
    assign w_c2_on = (w_cnt_x >= w_c2_start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_dt1_s <= '0;
            r_dt2_s <= '0;
        end else begin
            r_cnt <= enable ? r_cnt + 1'b1 : '0;
            if (w_load) begin
                r_dt1_s <= i_dt1;
                r_dt2_s <= i_dt2;
            end
        end
    end

`ifdef SOFT_START_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_eff   <= '0;
            o_ss_done <= 1'b0;
        end else begin
            if (!enable) begin
                r_d_eff <= '0;
            end else if (w_at_max) begin
                // Ramp up one count per period; downward steps are applied at once.
                r_d_eff <= (r_d_eff < i_duty) ? r_d_eff + 1'b1 : i_duty;
            end
            o_ss_done <= enable && (r_d_eff == i_duty);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_eff   <= '0;
            o_ss_done <= 1'b0;
        end else begin
            if (w_load) begin
                r_d_eff <= i_duty;
            end
            o_ss_done <= enable;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_c1     <= 1'b0;
            o_c2     <= 1'b0;
            o_period <= 1'b0;
        end else begin
            o_c1     <= enable && w_c1_on;
            o_c2     <= enable && w_c2_on;
            o_period <= enable && (r_cnt == '0);
        end
    end

endmodule

`default_nettype wire
